// File: rtl/adc_spi_sequencer.sv
// adc_spi_sequencer: dual-ADC SPI burst sequencer with a DSP-bus register window.
// Both ADCs share SCLK/CS_n/DOUT; results land in a 10-word read window.
module adc_spi_sequencer #(
    parameter int unsigned CLK_DIV   = 10,
    parameter logic [13:0] ADDR_BASE = 14'h0060
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SOC,
    input  logic        wr_en,
    input  logic [13:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic        rd_en,
    input  logic [13:0] rd_addr,
    output logic [15:0] rd_data,
    output logic        rd_hit,
    output logic        adc_sclk,
    output logic        adc_cs_n,
    output logic        adc_dout,
    input  logic        adc_din1,
    input  logic        adc_din2,
    output logic        busy,
    output logic        eoc
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, DONE} state_t;

    localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [4:0]  hc_q, hc_d;          // SCLK half-period index inside SHIFT
    logic [1:0]  ch_q, ch_d;
    logic [1:0]  nch_q;
    logic [2:0]  ctrl_q;              // {NCH[1:0], CONT}
    logic        go_q, ovr_q, valid_q;
    logic        soc_s1_q, soc_s2_q, soc_s3_q, soc_edge_q;
    logic [15:0] sr1_q, sr2_q;
    logic [15:0] res1_q [4];
    logic [15:0] res2_q [4];
    logic        sclk_q, cs_n_q, dout_q, busy_q, eoc_q;
    logic        sclk_d, cs_n_d, dout_d;
    logic        start_req, burst_start, sample_now, result_we;
    logic        wr_ctrl, wr_status, rd_hit_d;
    logic [13:0] wr_off, rd_off;
    logic [1:0]  rd_idx;
    logic [15:0] cmd, rd_mux, rd_data_q;
    logic [3:0]  bit_sel;
    logic        rd_hit_q;
    logic        unused_wr_data;

    assign wr_off         = wr_addr - ADDR_BASE;
    assign rd_off         = rd_addr - ADDR_BASE;
    assign rd_idx         = rd_off[1:0] - 2'd2;
    assign wr_ctrl        = wr_en && (wr_off == 14'd0);
    assign wr_status      = wr_en && (wr_off == 14'd1);
    assign start_req      = go_q | soc_edge_q;
    assign sample_now     = (state_q == SHIFT) && (cnt_q == HALF_LAST) && !hc_q[0];
    assign result_we      = (state_q == HOLD) && (cnt_q == 9'd0);
    assign rd_hit_d       = rd_en && (rd_off < 14'd10);
    assign unused_wr_data = ^wr_data[15:4];

    assign adc_sclk = sclk_q;
    assign adc_cs_n = cs_n_q;
    assign adc_dout = dout_q;
    assign busy     = busy_q;
    assign eoc      = eoc_q;
    assign rd_data  = rd_data_q;
    assign rd_hit   = rd_hit_q;

    // Synchronise SOC and register its rising edge as a one-cycle request.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            soc_s1_q   <= 1'b0;
            soc_s2_q   <= 1'b0;
            soc_s3_q   <= 1'b0;
            soc_edge_q <= 1'b0;
        end else begin
            soc_s1_q   <= SOC;
            soc_s2_q   <= soc_s1_q;
            soc_s3_q   <= soc_s2_q;
            soc_edge_q <= soc_s2_q & ~soc_s3_q;
        end
    end

    // Burst sequencing: next state, timers and next values of the SPI pins.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 9'd1;
        hc_d        = hc_q;
        ch_d        = ch_q;
        burst_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_req) begin
                    state_d     = SETUP;
                    ch_d        = '0;
                    burst_start = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    hc_d    = '0;
                end
            end
            SHIFT: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (hc_q == 5'd31) state_d = HOLD;
                    else               hc_d    = hc_q + 5'd1;
                end
            end
            HOLD: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (ch_q < nch_q) begin
                        state_d = SETUP;
                        ch_d    = ch_q + 2'd1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                cnt_d = '0;
                // CONT is read live here so clearing it mid-burst stops after this burst.
                if (ctrl_q[0]) begin
                    state_d     = SETUP;
                    ch_d        = '0;
                    burst_start = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        cmd     = {1'b1, ch_q, 13'b0};
        bit_sel = 4'd15 - hc_d[4:1];
        sclk_d  = (state_d == SHIFT) ? hc_d[0] : 1'b1;
        cs_n_d  = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
        dout_d  = (state_d == SHIFT) ? cmd[bit_sel] : 1'b0;
    end

    // State register with registered SPI pins, busy and eoc.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hc_q    <= '0;
            ch_q    <= '0;
            nch_q   <= '0;
            sclk_q  <= 1'b1;
            cs_n_q  <= 1'b1;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            eoc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hc_q    <= hc_d;
            ch_q    <= ch_d;
            if (burst_start) nch_q <= ctrl_q[2:1];
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            dout_q  <= dout_d;
            busy_q  <= (state_d != IDLE);
            eoc_q   <= (state_d == DONE);
        end
    end

    // Capture both ADC streams on SCLK rising edges and store them on the first HOLD cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sr1_q <= '0;
            sr2_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                res1_q[i] <= '0;
                res2_q[i] <= '0;
            end
        end else begin
            if (sample_now) begin
                sr1_q <= {sr1_q[14:0], adc_din1};
                sr2_q <= {sr2_q[14:0], adc_din2};
            end
            if (result_we) begin
                res1_q[ch_q] <= sr1_q;
                res2_q[ch_q] <= sr2_q;
            end
        end
    end

    // Control/status registers: GO pulse, sticky overrun and result-valid flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrl_q  <= '0;
            go_q    <= 1'b0;
            ovr_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            go_q <= wr_ctrl && wr_data[0];
            if (wr_ctrl) ctrl_q <= wr_data[3:1];
            if (start_req && (state_q != IDLE)) ovr_q <= 1'b1;
            else if (wr_status && wr_data[1])   ovr_q <= 1'b0;
            // A continuous-mode restart happens in DONE, so VALID stays set between bursts.
            if (state_q == DONE)  valid_q <= 1'b1;
            else if (burst_start) valid_q <= 1'b0;
        end
    end

    // Read-data select for the register window.
    always_comb begin
        rd_mux = '0;
        case (rd_off)
            14'd0:                      rd_mux = {12'b0, ctrl_q, 1'b0};
            14'd1:                      rd_mux = {13'b0, valid_q, ovr_q, busy_q};
            14'd2, 14'd3, 14'd4, 14'd5: rd_mux = res1_q[rd_idx];
            14'd6, 14'd7, 14'd8, 14'd9: rd_mux = res2_q[rd_idx];
            default:                    rd_mux = '0;
        endcase
    end

    // Registered read port: zero unless enabled and inside the window.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_data_q <= '0;
            rd_hit_q  <= 1'b0;
        end else begin
            rd_data_q <= rd_hit_d ? rd_mux : '0;
            rd_hit_q  <= rd_hit_d;
        end
    end
endmodule

// File: tb/tb_adc_spi_sequencer.sv
// Bench for adc_spi_sequencer: table-driven register reads, directed burst
// sequences and randomized bursts checked against a behavioural model.
`timescale 1ns/1ps
module tb_adc_spi_sequencer;
    localparam int unsigned CLK_DIV = 10;
    localparam logic [13:0] BASE    = 14'h0060;
    localparam int          FRAME   = 36 * CLK_DIV;

    logic        CLK = 1'b0, RESET = 1'b1, SOC = 1'b0;
    logic        wr_en = 1'b0, rd_en = 1'b0, adc_din1 = 1'b0, adc_din2 = 1'b0;
    logic [13:0] wr_addr = '0, rd_addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd_data;
    logic        rd_hit, adc_sclk, adc_cs_n, adc_dout, busy, eoc;

    int checks = 0;
    int errors = 0;

    adc_spi_sequencer #(.CLK_DIV(CLK_DIV), .ADDR_BASE(BASE)) dut (
        .CLK(CLK), .RESET(RESET), .SOC(SOC),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_hit(rd_hit),
        .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n), .adc_dout(adc_dout),
        .adc_din1(adc_din1), .adc_din2(adc_din2),
        .busy(busy), .eoc(eoc)
    );

    always #2.5 CLK = ~CLK;

    // ADC models: frame index within the burst selects the returned words.
    typedef struct { logic [15:0] cmd; int falls; int rises; } frame_t;
    frame_t      frames[$];
    logic [15:0] w1 [4];
    logic [15:0] w2 [4];
    int          fr = 0, bitn = 0, nf = 0, nr = 0;
    logic [15:0] cmd_sh = '0;
    logic        cs_prev = 1'b1, sclk_prev = 1'b1;

    always @(negedge CLK) begin
        logic [15:0] v1, v2;
        if (RESET) begin
            fr = 0; bitn = 0; nf = 0; nr = 0;
        end else begin
            if (cs_prev && !adc_cs_n) begin
                bitn = 0; nf = 0; nr = 0; cmd_sh = '0;
            end
            if (!adc_cs_n && sclk_prev && !adc_sclk) begin
                v1 = w1[fr % 4];
                v2 = w2[fr % 4];
                if (bitn < 16) begin
                    adc_din1 = v1[15 - bitn];
                    adc_din2 = v2[15 - bitn];
                end
                bitn++; nf++;
            end
            if (!adc_cs_n && !sclk_prev && adc_sclk) begin
                cmd_sh = {cmd_sh[14:0], adc_dout};
                nr++;
            end
            if (!cs_prev && adc_cs_n) begin
                frames.push_back('{cmd_sh, nf, nr});
                fr++;
            end
            if (eoc) fr = 0;
        end
        cs_prev   = adc_cs_n;
        sclk_prev = adc_sclk;
    end

    // Reference register contents.
    logic [15:0] exp1 [4];
    logic [15:0] exp2 [4];
    logic [15:0] exp_ctrl   = '0;
    logic [15:0] exp_status = '0;

    function automatic logic [15:0] model_read(input int off);
        if (off == 0) return exp_ctrl & 16'h000E;
        if (off == 1) return exp_status;
        if (off >= 2 && off <= 5) return exp1[off - 2];
        if (off >= 6 && off <= 9) return exp2[off - 6];
        return 16'h0000;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [13:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic check_read(input string name, input logic [13:0] a,
                              input logic exp_hit, input logic [15:0] exp_data);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        check({name, " hit"}, rd_hit, exp_hit);
        check({name, " data"}, rd_data, exp_data);
    endtask

    task automatic wait_eoc(input int max, output int n, output int nb);
        n = 0; nb = 0;
        while (n < max) begin
            tick();
            n++;
            if (eoc) break;
            if (busy) nb++;
        end
        check("eoc seen", eoc, 1'b1);
    endtask

    task automatic check_frames(input int nch);
        frame_t f;
        check("frame count", frames.size(), nch + 1);
        for (int c = 0; c <= nch; c++) begin
            if (frames.size() == 0) break;
            f = frames.pop_front();
            check("command word", f.cmd, 16'h8000 | (16'(c) << 13));
            check("sclk falls", f.falls, 16);
            check("sclk rises", f.rises, 16);
        end
        frames.delete();
    endtask

    task automatic count_cs_low(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (!adc_cs_n) lows++;
        end
    endtask

    typedef struct { logic [13:0] addr; logic hit; logic [15:0] data; } rdvec_t;
    rdvec_t tbl [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nb, lows, nch, off;
        logic use_soc;

        tbl[0] = '{BASE,          1'b1, 16'h0000};
        tbl[1] = '{BASE + 14'd1,  1'b1, 16'h0004};
        tbl[2] = '{BASE + 14'd2,  1'b1, 16'hA5C3};
        tbl[3] = '{BASE + 14'd3,  1'b1, 16'h0000};
        tbl[4] = '{BASE + 14'd5,  1'b1, 16'h0000};
        tbl[5] = '{BASE + 14'd6,  1'b1, 16'h3C5A};
        tbl[6] = '{BASE + 14'd9,  1'b1, 16'h0000};
        tbl[7] = '{BASE + 14'd10, 1'b0, 16'h0000};
        tbl[8] = '{BASE - 14'd1,  1'b0, 16'h0000};
        tbl[9] = '{14'h0000,      1'b0, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            w1[i] = '0; w2[i] = '0; exp1[i] = '0; exp2[i] = '0;
        end

        // Reset values
        RESET = 1'b1;
        repeat (3) tick();
        RESET = 1'b0;
        check("rst cs_n", adc_cs_n, 1'b1);
        check("rst sclk", adc_sclk, 1'b1);
        check("rst dout", adc_dout, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst eoc", eoc, 1'b0);
        check("rst rd_data", rd_data, 16'h0000);
        check("rst rd_hit", rd_hit, 1'b0);
        check_read("rst ctrl", BASE, 1'b1, 16'h0000);
        check_read("rst status", BASE + 14'd1, 1'b1, 16'h0000);

        // Single channel started from SOC
        w1[0] = 16'hA5C3; w2[0] = 16'h3C5A;
        bus_write(BASE, 16'h0000);
        SOC = 1'b1;
        repeat (3) tick();
        check("soc latency early", adc_cs_n, 1'b1);
        tick();
        check("soc latency", adc_cs_n, 1'b0);
        check("busy with cs", busy, 1'b1);
        wait_eoc(2000, n, nb);
        check("single eoc cycles", n, FRAME);
        check_frames(0);
        tick();
        check("single busy after done", busy, 1'b0);
        count_cs_low(20, lows);
        check("soc held single start", lows, 0);
        SOC = 1'b0;
        bus_write(BASE + 14'd2, 16'hFFFF);
        for (int i = 0; i < 10; i++) begin
            check_read("table read", tbl[i].addr, tbl[i].hit, tbl[i].data);
            tick();
            check("read release hit", rd_hit, 1'b0);
            check("read release data", rd_data, 16'h0000);
        end
        exp1[0] = 16'hA5C3; exp2[0] = 16'h3C5A; exp_status = 16'h0004;

        // Four channels started from GO
        for (int i = 0; i < 4; i++) begin
            w1[i] = 16'h1000 + 16'(i);
            w2[i] = 16'h2000 + 16'(i);
        end
        bus_write(BASE, 16'h000D);
        check("go latency early", adc_cs_n, 1'b1);
        tick();
        check("go latency", adc_cs_n, 1'b0);
        wait_eoc(3000, n, nb);
        check("4ch eoc cycles", n, 4 * FRAME);
        check("4ch busy held", nb, 4 * FRAME - 1);
        check_frames(3);
        tick();
        check("4ch busy drop", busy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp1[i] = w1[i]; exp2[i] = w2[i];
        end
        exp_ctrl = 16'h000D;
        for (int o = 0; o < 10; o++) check_read("4ch read", BASE + 14'(o), 1'b1, model_read(o));

        // Overrun: SOC edge during a burst
        w1[0] = 16'h0BAD; w2[0] = 16'hBEEF;
        bus_write(BASE, 16'h0001);
        tick();
        check("ovr cs low", adc_cs_n, 1'b0);
        repeat (100) tick();
        SOC = 1'b1;
        repeat (4) tick();
        SOC = 1'b0;
        wait_eoc(2000, n, nb);
        check("ovr eoc cycles", n, FRAME - 104);
        check_frames(0);
        tick();
        check("ovr busy drop", busy, 1'b0);
        count_cs_low(20, lows);
        check("ovr request dropped", lows, 0);
        exp1[0] = w1[0]; exp2[0] = w2[0]; exp_ctrl = 16'h0001; exp_status = 16'h0006;
        check_read("ovr status", BASE + 14'd1, 1'b1, model_read(1));
        check_read("ovr result", BASE + 14'd2, 1'b1, model_read(2));
        bus_write(BASE + 14'd1, 16'h0002);
        exp_status = 16'h0004;
        check_read("ovr cleared", BASE + 14'd1, 1'b1, model_read(1));

        // Continuous mode, NCH=1
        w1[0] = 16'h1111; w1[1] = 16'h2222; w2[0] = 16'h3333; w2[1] = 16'h4444;
        bus_write(BASE, 16'h0007);
        tick();
        check("cont cs low", adc_cs_n, 1'b0);
        wait_eoc(3000, n, nb);
        check("cont eoc1", n, 2 * FRAME);
        check_frames(1);
        tick();
        check("cont busy stays", busy, 1'b1);
        check("cont restart", adc_cs_n, 1'b0);
        wait_eoc(3000, n, nb);
        check("cont eoc period", n, 2 * FRAME);
        check_frames(1);
        check_read("ctrl go clear", BASE, 1'b1, 16'h0006);
        repeat (99) tick();
        bus_write(BASE, 16'h0004);
        wait_eoc(3000, n, nb);
        check("cont last eoc", n, 2 * FRAME + 1 - 101);
        check_frames(1);
        tick();
        check("cont busy drop", busy, 1'b0);
        count_cs_low(800, lows);
        check("cont stopped", lows, 0);
        exp1[0] = w1[0]; exp1[1] = w1[1]; exp2[0] = w2[0]; exp2[1] = w2[1];
        exp_ctrl = 16'h0004;
        check_read("cont status", BASE + 14'd1, 1'b1, model_read(1));

        // Randomized bursts against the model
        for (int b = 0; b < 6; b++) begin
            nch     = int'($urandom_range(0, 3));
            use_soc = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                w1[i] = 16'($urandom);
                w2[i] = 16'($urandom);
            end
            if (use_soc) begin
                bus_write(BASE, 16'(nch << 2));
                SOC = 1'b1;
                repeat (3) tick();
                check("rnd soc early", adc_cs_n, 1'b1);
                tick();
                check("rnd soc start", adc_cs_n, 1'b0);
            end else begin
                bus_write(BASE, 16'(nch << 2) | 16'h0001);
                check("rnd go early", adc_cs_n, 1'b1);
                tick();
                check("rnd go start", adc_cs_n, 1'b0);
            end
            wait_eoc(6000, n, nb);
            check("rnd eoc cycles", n, (nch + 1) * FRAME);
            SOC = 1'b0;
            check_frames(nch);
            for (int i = 0; i <= nch; i++) begin
                exp1[i] = w1[i]; exp2[i] = w2[i];
            end
            exp_ctrl = 16'(nch << 2);
            exp_status = 16'h0004;
            tick();
            for (int o = 0; o < 10; o++) check_read("rnd read", BASE + 14'(o), 1'b1, model_read(o));
            off = 10 + int'($urandom_range(0, 200));
            check_read("rnd outside", BASE + 14'(off), 1'b0, model_read(off));
        end

        // Reset in the middle of SHIFT
        w1[0] = 16'hDEAD; w2[0] = 16'hF00D;
        bus_write(BASE, 16'h0001);
        tick();
        repeat (150) tick();
        RESET = 1'b1;
        tick();
        check("mid rst cs_n", adc_cs_n, 1'b1);
        check("mid rst sclk", adc_sclk, 1'b1);
        check("mid rst busy", busy, 1'b0);
        check("mid rst dout", adc_dout, 1'b0);
        RESET = 1'b0;
        count_cs_low(400, lows);
        check("mid rst idle", lows, 0);
        check_read("mid rst result", BASE + 14'd2, 1'b1, 16'h0000);
        check_read("mid rst status", BASE + 14'd1, 1'b1, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
